// File: rtl/systolic_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_pkg
// Shared definitions for the systolic operand skew feeder: the FSM state type
// and the derivation helpers for lane count, step counter width and the index
// of the final step of an operation.
// -----------------------------------------------------------------------------
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } feed_state_e;

    // Number of lanes: elements carried by one bus word.
    function automatic int calc_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Step counter must reach 2*DIM-2.
    function automatic int calc_step_w(input int dim);
        return (dim > 1) ? $clog2(2 * dim) : 1;
    endfunction

    // Index of the final skewed step of one operation.
    function automatic int last_step(input int dim);
        return (2 * dim) - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder_skew_lane
// One skew lane: holds the DIM elements of one A row and one B column and
// presents element (step - LANE) of each, or zero with vld_o low when that
// index falls outside the row.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   load_i               capture a_word_i/b_word_i into the lane buffer
//   upd_i                register the element selected by step_i
//   clr_i                force outputs to zero
//   a_word_i, b_word_i   operand words (also used directly on the load cycle)
//   step_i               step index that the outputs will show next cycle
//   a_elem_o, b_elem_o   registered lane elements
//   vld_o                registered element-valid flag
// -----------------------------------------------------------------------------
module systolic_skew_feeder_skew_lane
    import systolic_skew_feeder_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = calc_dim(BUS_WIDTH, DATA_WIDTH),
    parameter int STEP_W     = calc_step_w(DIM),
    parameter int LANE       = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  upd_i,
    input  logic                  clr_i,
    input  logic [BUS_WIDTH-1:0]  a_word_i,
    input  logic [BUS_WIDTH-1:0]  b_word_i,
    input  logic [STEP_W-1:0]     step_i,
    output logic [DATA_WIDTH-1:0] a_elem_o,
    output logic [DATA_WIDTH-1:0] b_elem_o,
    output logic                  vld_o
);

    localparam logic [STEP_W-1:0] WIN_LO = STEP_W'(LANE);

    logic [BUS_WIDTH-1:0]  a_buf_r;
    logic [BUS_WIDTH-1:0]  b_buf_r;
    logic [BUS_WIDTH-1:0]  a_src_s;
    logic [BUS_WIDTH-1:0]  b_src_s;
    logic [STEP_W:0]       diff_s;
    logic                  in_win_s;
    logic [DATA_WIDTH-1:0] a_sel_s;
    logic [DATA_WIDTH-1:0] b_sel_s;

    // Element selection: the borrow bit of step-LANE flags steps before this
    // lane starts; the load cycle reads the incoming word since the buffer
    // only captures it on the same edge.
    always_comb begin
        a_src_s  = load_i ? a_word_i : a_buf_r;
        b_src_s  = load_i ? b_word_i : b_buf_r;
        diff_s   = {1'b0, step_i} - {1'b0, WIN_LO};
        in_win_s = !diff_s[STEP_W] && (diff_s[STEP_W-1:0] < STEP_W'(DIM));
        a_sel_s  = '0;
        b_sel_s  = '0;
        for (int j = 0; j < DIM; j++) begin
            a_sel_s = a_sel_s | (a_src_s[j*DATA_WIDTH +: DATA_WIDTH]
                                 & {DATA_WIDTH{diff_s[STEP_W-1:0] == STEP_W'(j)}});
            b_sel_s = b_sel_s | (b_src_s[j*DATA_WIDTH +: DATA_WIDTH]
                                 & {DATA_WIDTH{diff_s[STEP_W-1:0] == STEP_W'(j)}});
        end
    end

    // Lane buffer and registered lane outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_buf_r  <= '0;
            b_buf_r  <= '0;
            a_elem_o <= '0;
            b_elem_o <= '0;
            vld_o    <= 1'b0;
        end else begin
            if (load_i) begin
                a_buf_r <= a_word_i;
                b_buf_r <= b_word_i;
            end
            if (clr_i) begin
                a_elem_o <= '0;
                b_elem_o <= '0;
                vld_o    <= 1'b0;
            end else if (upd_i) begin
                a_elem_o <= in_win_s ? a_sel_s : '0;
                b_elem_o <= in_win_s ? b_sel_s : '0;
                vld_o    <= in_win_s;
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Captures a DIMxDIM A-row block and B-column block on start_i and streams
// 2*DIM-1 skewed steps (lane k delayed k steps, zero padded) to a systolic
// array, with stall (hold_i), per-step valid, busy and done flags.
// Optional feature macro FLOW_CTRL_PRELOAD_EN: a start_i during FEED loads a
// shadow buffer, and the queued operation begins right after the last step
// with no IDLE/DONE gap.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   start_i         begin an operation; operands sampled on the same edge
//   hold_i          stall request from the array
//   a_row_i         A rows, row r elem j at [r*BUS_WIDTH + j*DATA_WIDTH]
//   b_col_i         B columns, same packing
//   a_data_o        lane r A element at [r*DATA_WIDTH]
//   b_data_o        lane c B element, same packing
//   lane_vld_o      per-lane element-valid mask
//   valid_o         current step is live (not a stalled repeat)
//   step_o          current step index 0..2*DIM-2
//   busy_o          operation in progress
//   done_o          one-cycle pulse after the last step
// -----------------------------------------------------------------------------
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = calc_dim(BUS_WIDTH, DATA_WIDTH),
    parameter int STEP_W     = calc_step_w(DIM)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      hold_i,
    input  logic [DIM*BUS_WIDTH-1:0]  a_row_i,
    input  logic [DIM*BUS_WIDTH-1:0]  b_col_i,
    output logic [DIM*DATA_WIDTH-1:0] a_data_o,
    output logic [DIM*DATA_WIDTH-1:0] b_data_o,
    output logic [DIM-1:0]            lane_vld_o,
    output logic                      valid_o,
    output logic [STEP_W-1:0]         step_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(last_step(DIM));

    feed_state_e              state_r;
    feed_state_e              state_nxt_s;
    logic [STEP_W-1:0]        step_r;
    logic [STEP_W-1:0]        step_nxt_s;
    logic                     valid_r;
    logic                     valid_nxt_s;
    logic                     busy_r;
    logic                     busy_nxt_s;
    logic                     done_r;
    logic                     done_nxt_s;
    logic                     load_s;
    logic                     upd_s;
    logic                     clr_s;
    logic                     last_acc_s;
    logic                     chain_s;
    logic [DIM*BUS_WIDTH-1:0] a_load_s;
    logic [DIM*BUS_WIDTH-1:0] b_load_s;

`ifdef FLOW_CTRL_PRELOAD_EN
    logic                     pending_r;
    logic                     shadow_cap_s;
    logic [DIM*BUS_WIDTH-1:0] a_shadow_r;
    logic [DIM*BUS_WIDTH-1:0] b_shadow_r;
`endif

    // Last-step acceptance, chaining decision and operand source for a load.
    always_comb begin
        last_acc_s = (state_r == ST_FEED) && !hold_i && (step_r == LAST_STEP);
`ifdef FLOW_CTRL_PRELOAD_EN
        // A start on the final accepted edge chains straight from the inputs;
        // otherwise a queued shadow block takes priority and start_i is dropped.
        chain_s      = last_acc_s && (pending_r || start_i);
        shadow_cap_s = (state_r == ST_FEED) && start_i && !pending_r && !last_acc_s;
        a_load_s     = pending_r ? a_shadow_r : a_row_i;
        b_load_s     = pending_r ? b_shadow_r : b_col_i;
`else
        chain_s  = 1'b0;
        a_load_s = a_row_i;
        b_load_s = b_col_i;
`endif
    end

`ifdef FLOW_CTRL_PRELOAD_EN
    // Shadow operand buffer and pending flag for the queued operation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_r  <= 1'b0;
            a_shadow_r <= '0;
            b_shadow_r <= '0;
        end else if (chain_s) begin
            pending_r <= 1'b0;
        end else if (shadow_cap_s) begin
            pending_r  <= 1'b1;
            a_shadow_r <= a_row_i;
            b_shadow_r <= b_col_i;
        end
    end
`endif

    // State register and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            step_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt_s = ST_FEED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (last_acc_s) begin
                    state_nxt_s = chain_s ? ST_FEED : ST_DONE;
                end else begin
                    state_nxt_s = ST_FEED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath control for the coming cycle; a held step leaves the
    // lanes untouched so data and lane_vld_o stay frozen.
    always_comb begin
        step_nxt_s  = step_r;
        load_s      = 1'b0;
        upd_s       = 1'b0;
        clr_s       = 1'b0;
        valid_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                step_nxt_s = '0;
                if (start_i) begin
                    load_s      = 1'b1;
                    upd_s       = 1'b1;
                    valid_nxt_s = 1'b1;
                end else begin
                    clr_s = 1'b1;
                end
            end
            ST_FEED: begin
                if (hold_i) begin
                    step_nxt_s = step_r;
                end else if (step_r == LAST_STEP) begin
                    step_nxt_s = '0;
                    done_nxt_s = 1'b1;
                    if (chain_s) begin
                        load_s      = 1'b1;
                        upd_s       = 1'b1;
                        valid_nxt_s = 1'b1;
                    end else begin
                        clr_s = 1'b1;
                    end
                end else begin
                    step_nxt_s  = step_r + STEP_W'(1);
                    upd_s       = 1'b1;
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                step_nxt_s = '0;
                clr_s      = 1'b1;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_FEED);
    end

    for (genvar r = 0; r < DIM; r++) begin : g_lane
        systolic_skew_feeder_skew_lane #(
            .BUS_WIDTH  (BUS_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .DIM        (DIM),
            .STEP_W     (STEP_W),
            .LANE       (r)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load_i   (load_s),
            .upd_i    (upd_s),
            .clr_i    (clr_s),
            .a_word_i (a_load_s[r*BUS_WIDTH +: BUS_WIDTH]),
            .b_word_i (b_load_s[r*BUS_WIDTH +: BUS_WIDTH]),
            .step_i   (step_nxt_s),
            .a_elem_o (a_data_o[r*DATA_WIDTH +: DATA_WIDTH]),
            .b_elem_o (b_data_o[r*DATA_WIDTH +: DATA_WIDTH]),
            .vld_o    (lane_vld_o[r])
        );
    end

    assign step_o  = step_r;
    assign valid_o = valid_r;
    assign busy_o  = busy_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Self-checking bench for systolic_skew_feeder (BUS_WIDTH=32, DATA_WIDTH=8,
// DIM=4). Expected lane values are computed per step from the operand blocks:
// lane r at step t shows element t-r of row r when 0<=t-r<4, else zero.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

    localparam int LAST = 6;

    logic         clk;
    logic         rst_ni;
    logic         start_i;
    logic         hold_i;
    logic [127:0] a_row_i;
    logic [127:0] b_col_i;
    logic [31:0]  a_data_o;
    logic [31:0]  b_data_o;
    logic [3:0]   lane_vld_o;
    logic         valid_o;
    logic [2:0]   step_o;
    logic         busy_o;
    logic         done_o;

    int checks;
    int errors;

    logic [127:0] cur_av;
    logic [127:0] cur_bv;
    logic [127:0] nxt_av;
    logic [127:0] nxt_bv;
    logic [31:0]  cap_a [0:6];
    logic [3:0]   cap_v [0:6];

    systolic_skew_feeder #(
        .BUS_WIDTH  (32),
        .DATA_WIDTH (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .hold_i     (hold_i),
        .a_row_i    (a_row_i),
        .b_col_i    (b_col_i),
        .a_data_o   (a_data_o),
        .b_data_o   (b_data_o),
        .lane_vld_o (lane_vld_o),
        .valid_o    (valid_o),
        .step_o     (step_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Skewed bus expected at step t for operand block m.
    function automatic logic [31:0] exp_bus(input logic [127:0] m, input int t);
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) begin
            int e;
            e = t - r;
            if (e >= 0 && e < 4) v[r*8 +: 8] = m[r*32 + e*8 +: 8];
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_vld(input int t);
        logic [3:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) begin
            if (t - r >= 0 && t - r < 4) v[r] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        a_row_i = cur_av;
        b_col_i = cur_bv;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Walks one operation from step 0 onwards, stalling hold_len cycles at
    // step hold_at and pulsing start_i with the nxt block at step pre_at.
    task automatic feed_check(input int hold_at, input int hold_len,
                              input int pre_at, input bit done_first);
        int t;
        int held;
        int guard;
        bit fresh;
        t = 0; held = 0; guard = 0; fresh = 1'b1;
        while (t <= LAST && guard < 60) begin
            chk("step", step_o, t);
            chk("a_data", a_data_o, exp_bus(cur_av, t));
            chk("b_data", b_data_o, exp_bus(cur_bv, t));
            chk("lane_vld", lane_vld_o, exp_vld(t));
            chk("valid", valid_o, fresh);
            chk("busy", busy_o, 1'b1);
            chk("done_in_feed", done_o, (t == 0) && fresh && done_first);
            if (fresh) begin
                cap_a[t] = a_data_o;
                cap_v[t] = lane_vld_o;
            end
            hold_i  = (t == hold_at) && (held < hold_len);
            start_i = (t == pre_at) && fresh;
            if (start_i) begin
                a_row_i = nxt_av;
                b_col_i = nxt_bv;
            end else begin
                a_row_i = rnd128();
                b_col_i = rnd128();
            end
            tick();
            start_i = 1'b0;
            if (hold_i) begin
                held++;
                fresh = 1'b0;
            end else begin
                t++;
                fresh = 1'b1;
            end
            guard++;
        end
        hold_i = 1'b0;
        if (guard >= 60) chk("feed_timeout", 1'b1, 1'b0);
    endtask

    task automatic end_check();
        chk("done_pulse", done_o, 1'b1);
        chk("busy_end", busy_o, 1'b0);
        chk("valid_end", valid_o, 1'b0);
        chk("step_end", step_o, 3'd0);
        chk("a_end", a_data_o, 32'd0);
        chk("b_end", b_data_o, 32'd0);
        chk("vld_end", lane_vld_o, 4'd0);
    endtask

    task automatic idle_check();
        tick();
        chk("done_idle", done_o, 1'b0);
        chk("busy_idle", busy_o, 1'b0);
        chk("valid_idle", valid_o, 1'b0);
        chk("step_idle", step_o, 3'd0);
        chk("vld_idle", lane_vld_o, 4'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        hold_i  = 1'b0;
        a_row_i = '0;
        b_col_i = '0;

        // 1: reset held for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_a", a_data_o, 32'd0);
            chk("rst_vld", lane_vld_o, 4'd0);
            chk("rst_flags", {valid_o, busy_o, done_o, step_o}, 6'd0);
        end
        rst_ni = 1'b1;
        idle_check();

        // 2: reference block, no stall
        cur_av = 128'hBEEF_FFEC_12CC_ABAC_EFEF_5678_ABCD_1234;
        cur_bv = rnd128();
        launch();
        feed_check(-1, 0, -1, 1'b0);
        end_check();
        chk("ref_s0_a", cap_a[0], 32'h0000_0034);
        chk("ref_s0_vld", cap_v[0], 4'b0001);
        chk("ref_s3_vld", cap_v[3], 4'b1111);
        chk("ref_s3_lane0", cap_a[3][7:0], 8'hAB);
        chk("ref_s3_lane3", cap_a[3][31:24], 8'hEC);
        chk("ref_s6_vld", cap_v[6], 4'b1000);
        chk("ref_s6_lane3", cap_a[6][31:24], 8'hBE);
        idle_check();

        // 3: three-cycle stall at step 2
        cur_av = rnd128();
        cur_bv = rnd128();
        launch();
        feed_check(2, 3, -1, 1'b0);
        end_check();
        idle_check();

        // 4: reset in the middle of an operation at step 4
        cur_av = rnd128();
        cur_bv = rnd128();
        launch();
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_step", step_o, 3'd4);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("midrst_a", a_data_o, 32'd0);
        chk("midrst_b", b_data_o, 32'd0);
        chk("midrst_flags", {lane_vld_o, valid_o, busy_o, done_o, step_o}, 10'd0);
        for (int i = 0; i < 3; i++) idle_check();
        launch();
        feed_check(-1, 0, -1, 1'b0);
        end_check();
        idle_check();

        // 5: start_i during FEED at step 3
        cur_av = rnd128();
        cur_bv = rnd128();
        nxt_av = rnd128();
        nxt_bv = rnd128();
        launch();
        feed_check(-1, 0, 3, 1'b0);
`ifdef FLOW_CTRL_PRELOAD_EN
        cur_av = nxt_av;
        cur_bv = nxt_bv;
        feed_check(-1, 0, -1, 1'b1);
        end_check();
`else
        end_check();
`endif
        idle_check();

        // 6: start_i in the DONE cycle
        cur_av = rnd128();
        cur_bv = rnd128();
        launch();
        feed_check(-1, 0, -1, 1'b0);
        end_check();
        cur_av = rnd128();
        cur_bv = rnd128();
        launch();
        feed_check(-1, 0, -1, 1'b0);
        end_check();
        idle_check();

        // Randomised operands and stall placement
        for (int k = 0; k < 6; k++) begin
            cur_av = rnd128();
            cur_bv = rnd128();
            launch();
            feed_check(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, 1'b0);
            end_check();
            idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
